// File: rtl/aq_gemac_mdio_master_if.sv
// MDIO master bundle: host request/response signals plus the MDC/MDIO pad
// signals. The master modport is the management block; the slave modport is
// the host/PHY side that drives requests and the pad input.
interface aq_gemac_mdio_master_if;
    logic        miim_request;
    logic [1:0]  miim_op;
    logic        miim_clause45;
    logic [4:0]  miim_phy_address;
    logic [4:0]  miim_reg_address;
    logic [15:0] miim_wdata;
    logic [15:0] miim_rdata;
    logic        miim_rvalid;
    logic        miim_error;
    logic        miim_busy;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_out_enable;

    modport master (
        input  miim_request, miim_op, miim_clause45, miim_phy_address,
               miim_reg_address, miim_wdata, mdio_in,
        output miim_rdata, miim_rvalid, miim_error, miim_busy,
               mdc, mdio_out, mdio_out_enable
    );

    modport slave (
        output miim_request, miim_op, miim_clause45, miim_phy_address,
               miim_reg_address, miim_wdata, mdio_in,
        input  miim_rdata, miim_rvalid, miim_error, miim_busy,
               mdc, mdio_out, mdio_out_enable
    );
endinterface

// File: rtl/aq_gemac_mdio_master.sv
// MDIO (MIIM) management master. Serialises Clause 22 frames, and Clause 45
// frames when built with AQ_GEMAC_MDIO_C45_EN defined, onto MDC/MDIO.
// Each bit-time lasts CLK_DIV clocks: MDC low for the first half, high for the
// second; MDIO is launched at count 0 and MDIO_IN is captured at MDC rise.
module aq_gemac_mdio_master #(
    parameter int CLK_DIV       = 50,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    aq_gemac_mdio_master_if.master        mdio_if
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int HALF  = CLK_DIV / 2;

    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic               c45_q, c45_d;
    logic               read_q, read_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         phy_q, phy_d;
    logic [4:0]         reg_q, reg_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        shift_q, shift_d;
    logic               no_resp_q, no_resp_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               error_q, error_d;
    logic               mdc_q, mdc_d;
    logic               mdio_out_q, mdio_out_d;
    logic               oe_q, oe_d;
    logic               c45_req;
    logic               legal_req;
    logic [3:0]         idx;

`ifdef AQ_GEMAC_MDIO_C45_EN
    assign c45_req = mdio_if.miim_clause45;
`else
    // Clause 45 framing not built: the select input is forced to Clause 22.
    assign c45_req = mdio_if.miim_clause45 & 1'b0;
`endif

    assign legal_req = c45_req || (mdio_if.miim_op == 2'b01) || (mdio_if.miim_op == 2'b10);

    // Number of bit-times spent in each frame field.
    function automatic logic [5:0] field_len(input state_t s);
        case (s)
            S_PREAMBLE:         field_len = 6'(PREAMBLE_BITS);
            S_ST, S_OP, S_TA:   field_len = 6'd2;
            S_PHYAD, S_REGAD:   field_len = 6'd5;
            S_DATA:             field_len = 6'd16;
            default:            field_len = 6'd1;
        endcase
    endfunction

    function automatic state_t field_next(input state_t s);
        case (s)
            S_PREAMBLE: field_next = S_ST;
            S_ST:       field_next = S_OP;
            S_OP:       field_next = S_PHYAD;
            S_PHYAD:    field_next = S_REGAD;
            S_REGAD:    field_next = S_TA;
            S_TA:       field_next = S_DATA;
            S_DATA:     field_next = S_GAP;
            default:    field_next = S_IDLE;
        endcase
    endfunction

    // Next-state, capture and pad-output computation.
    always_comb begin
        // NOTE: every variable gets its hold/default value before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        c45_d      = c45_q;
        read_d     = read_q;
        op_d       = op_q;
        phy_d      = phy_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        no_resp_d  = no_resp_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        error_d    = 1'b0;
        mdio_out_d = 1'b0;
        oe_d       = 1'b0;
        idx        = 4'd0;

        if (state_q == S_IDLE) begin
            if (mdio_if.miim_request) begin
                if (legal_req) begin
                    c45_d     = c45_req;
                    read_d    = mdio_if.miim_op[1];
                    op_d      = mdio_if.miim_op;
                    phy_d     = mdio_if.miim_phy_address;
                    reg_d     = mdio_if.miim_reg_address;
                    wdata_d   = mdio_if.miim_wdata;
                    no_resp_d = 1'b0;
                    div_d     = '0;
                    bit_d     = 6'd0;
                    state_d   = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_ST;
                end else begin
                    error_d = 1'b1;
                end
            end
        end else begin
            // Capture MDIO_IN at the MDC rising point of the bit-time.
            if (div_q == DIV_W'(HALF)) begin
                if (state_q == S_TA && bit_q == 6'd1) no_resp_d = mdio_if.mdio_in;
                if (state_q == S_DATA) shift_d = {shift_q[14:0], mdio_if.mdio_in};
            end
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d = '0;
                if (bit_q == field_len(state_q) - 6'd1) begin
                    bit_d   = 6'd0;
                    state_d = field_next(state_q);
                    if (state_q == S_GAP && read_q) begin
                        rdata_d  = shift_q;
                        rvalid_d = 1'b1;
                        error_d  = no_resp_q;
                    end
                end else begin
                    bit_d = bit_q + 6'd1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        // Bit position within the field, MSB first.
        idx = 4'(field_len(state_d) - 6'd1 - bit_d);
        case (state_d)
            S_PREAMBLE: begin mdio_out_d = 1'b1;            oe_d = 1'b1; end
            S_ST:       begin mdio_out_d = !c45_d && bit_d[0]; oe_d = 1'b1; end
            S_OP:       begin mdio_out_d = op_d[idx[0]];    oe_d = 1'b1; end
            S_PHYAD:    begin mdio_out_d = phy_d[idx[2:0]]; oe_d = 1'b1; end
            S_REGAD:    begin mdio_out_d = reg_d[idx[2:0]]; oe_d = 1'b1; end
            S_TA:       begin mdio_out_d = !read_d && (bit_d == 6'd0); oe_d = !read_d; end
            S_DATA:     begin mdio_out_d = !read_d && wdata_d[idx];    oe_d = !read_d; end
            default:    begin mdio_out_d = 1'b0;            oe_d = 1'b0; end
        endcase
        mdc_d = (state_d != S_IDLE) && (state_d != S_GAP) && (div_d >= DIV_W'(HALF));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= 6'd0;
            c45_q      <= 1'b0;
            read_q     <= 1'b0;
            op_q       <= 2'b00;
            phy_q      <= 5'd0;
            reg_q      <= 5'd0;
            wdata_q    <= 16'h0000;
            shift_q    <= 16'h0000;
            no_resp_q  <= 1'b0;
            rdata_q    <= 16'h0000;
            rvalid_q   <= 1'b0;
            error_q    <= 1'b0;
            mdc_q      <= 1'b0;
            mdio_out_q <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            c45_q      <= c45_d;
            read_q     <= read_d;
            op_q       <= op_d;
            phy_q      <= phy_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            shift_q    <= shift_d;
            no_resp_q  <= no_resp_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            error_q    <= error_d;
            mdc_q      <= mdc_d;
            mdio_out_q <= mdio_out_d;
            oe_q       <= oe_d;
        end
    end

    assign mdio_if.miim_busy       = (state_q != S_IDLE);
    assign mdio_if.miim_rdata      = rdata_q;
    assign mdio_if.miim_rvalid     = rvalid_q;
    assign mdio_if.miim_error      = error_q;
    assign mdio_if.mdc             = mdc_q;
    assign mdio_if.mdio_out        = mdio_out_q;
    assign mdio_if.mdio_out_enable = oe_q;
endmodule
